// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: per-stage bundle
// widths, control-bundle bit positions and the stage occupancy state.
package pipe_pkg;

  // Per-stage bundle widths (control, data).
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 10;
  localparam int IDEX_DATA_W  = 170;
  localparam int EXMEM_CTRL_W = 5;
  localparam int EXMEM_DATA_W = 137;
  localparam int MEMWB_CTRL_W = 3;
  localparam int MEMWB_DATA_W = 105;

  // Control bundle layout: {RegWrite, MemToReg[1:0], MemRead, MemWrite}.
  localparam int REGWRITE_B   = 4;
  localparam int MEMTOREG_LSB = 2;
  localparam int MEMREAD_B    = 1;
  localparam int MEMWRITE_B   = 0;

  // Number of entries held by the stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid bit plus opaque control and data bundles.
// Priority: rst > clear (bubble, data kept) > load > drop.
module pipe_entry_reg #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 137
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      // A flushed entry becomes a bubble; its data is left untouched.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry skid
// buffer, flush-to-bubble and a saturating downstream stall counter.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. in_ready never depends on in_valid; with SKID=1 it also never depends on
// out_ready. Once out_valid is raised the head is held stable until taken or
// flushed.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 137,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output state_e            dbg_state_o
);

  if (CTRL_W < 1 || DATA_W < 1) begin : g_bad_width
    $error("pipe_stage_hs: CTRL_W and DATA_W must both be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e state_q, state_d;

  logic              head_valid, skid_valid;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_ctrl_in;
  logic [DATA_W-1:0] head_data, skid_data, head_data_in;

  logic head_load, head_from_skid, head_drop;
  logic skid_load, skid_drop;
  logic in_xfer, out_xfer;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign out_xfer = head_valid & out_ready;
  // Input offered during a flush is discarded even if in_ready is high.
  assign in_xfer  = in_valid & in_ready & ~flush;

  // Occupancy FSM. With SKID=0 in_ready guarantees that an input in ONE always
  // coincides with an output, so TWO is never reached.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    head_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d   = ONE;
          head_load = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          state_d   = TWO;
          skid_load = 1'b1;
        end else if (in_xfer) begin
          head_load = 1'b1;
        end else if (out_xfer) begin
          state_d   = EMPTY;
          head_drop = 1'b1;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_d        = ONE;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
          skid_drop      = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  assign head_ctrl_in = head_from_skid ? skid_ctrl : in_ctrl;
  assign head_data_in = head_from_skid ? skid_data : in_data;

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_head (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .load_i  (head_load),
    .drop_i  (head_drop),
    .ctrl_i  (head_ctrl_in),
    .data_i  (head_data_in),
    .valid_o (head_valid),
    .ctrl_o  (head_ctrl),
    .data_o  (head_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry_reg #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clear_i (flush),
      .load_i  (skid_load),
      .drop_i  (skid_drop),
      .ctrl_i  (in_ctrl),
      .data_i  (in_data),
      .valid_o (skid_valid),
      .ctrl_o  (skid_ctrl),
      .data_o  (skid_data)
    );
    // Purely a register output: breaks the out_ready -> in_ready path.
    assign in_ready = ~skid_valid;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
    assign in_ready   = ~head_valid | out_ready;
  end

  // Stall counter: saturates, survives flush, cleared only by reset.
  always_comb begin
    cnt_d = cnt_q;
    if (head_valid && !out_ready && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_valid   = head_valid;
  assign out_ctrl    = head_valid ? head_ctrl : '0;
  assign out_data    = head_data;
  assign stall_cnt   = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: a SKID=1 instance (dut) and a SKID=0
// instance (dut0) with a FIFO scoreboard on each output.
module tb_pipe_stage_hs;
  import pipe_pkg::*;

  localparam int CW = 5;
  localparam int DW = 137;
  localparam int NW = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] stall_cnt;
  state_e        dbg_state;

  logic          in_valid0, in_ready0, out_valid0, out_ready0;
  logic [CW-1:0] in_ctrl0, out_ctrl0;
  logic [DW-1:0] in_data0, out_data0;
  logic [NW-1:0] stall_cnt0;
  state_e        dbg_state0;

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(NW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_data    (out_data),
    .stall_cnt   (stall_cnt),
    .dbg_state_o (dbg_state)
  );

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(NW)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid0),
    .in_ready    (in_ready0),
    .in_ctrl     (in_ctrl0),
    .in_data     (in_data0),
    .out_valid   (out_valid0),
    .out_ready   (out_ready0),
    .out_ctrl    (out_ctrl0),
    .out_data    (out_data0),
    .stall_cnt   (stall_cnt0),
    .dbg_state_o (dbg_state0)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [CW+DW-1:0] exp_q[$];
  logic [CW+DW-1:0] exp0_q[$];

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sampled mid-cycle; inputs are stable from posedge+1 until the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_skid_unexpected", exp_q.size(), 1);
        else                   chk("sb_skid_out", {out_ctrl, out_data}, exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp0_q.delete();
    end else begin
      if (out_valid0 && out_ready0) begin
        if (exp0_q.size() == 0) chk("sb_noskid_unexpected", exp0_q.size(), 1);
        else                    chk("sb_noskid_out", {out_ctrl0, out_data0}, exp0_q.pop_front());
      end
      if (flush) exp0_q.delete();
      else if (in_valid0 && in_ready0) exp0_q.push_back({in_ctrl0, in_data0});
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, 9'($urandom)};
  endfunction

  function automatic logic [CW-1:0] rnd_ctrl();
    return CW'($urandom_range(1, 31));
  endfunction

  // ---------------- directed sequence ----------------
  logic [DW-1:0] da, db, dc, d1, d2, dx, dy, d;
  logic [CW-1:0] ca, cb, cc, c;

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    in_valid0 = 1'b0; in_ctrl0 = '0; in_data0 = '0; out_ready0 = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_ready0", in_ready0, 1);

    // 1: single entry, one-cycle latency, bubble masks ctrl
    da = rnd_data();
    in_valid = 1'b1; in_ctrl = 5'b10111; in_data = da; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_ctrl", out_ctrl, 5'b10111);
    chk("t1_out_data", out_data, da);
    tick();
    chk("t1_bubble_valid", out_valid, 0);
    chk("t1_bubble_ctrl", out_ctrl, 0);

    // 2: fill skid with A,B; C refused until drained; FIFO order
    da = rnd_data(); db = rnd_data(); dc = rnd_data();
    ca = rnd_ctrl(); cb = rnd_ctrl(); cc = rnd_ctrl();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = ca; in_data = da;
    tick();
    in_ctrl = cb; in_data = db;
    chk("t2_ready_one", in_ready, 1);
    tick();
    in_ctrl = cc; in_data = dc;
    chk("t2_state_two", dbg_state, TWO);
    chk("t2_ready_two", in_ready, 0);
    tick();
    chk("t2_c_refused", in_ready, 0);
    chk("t2_head_a", out_data, da);
    chk("t2_head_a_ctrl", out_ctrl, ca);
    out_ready = 1'b1;
    tick();
    chk("t2_head_b", out_data, db);
    chk("t2_state_one", dbg_state, ONE);
    tick();
    in_valid = 1'b0;
    chk("t2_head_c", out_data, dc);
    chk("t2_head_c_ctrl", out_ctrl, cc);
    tick();
    chk("t2_drained", out_valid, 0);
    chk("t2_stall_cnt", stall_cnt, 2);

    // 3: flush in TWO with an input offered
    d1 = rnd_data(); d2 = rnd_data();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = rnd_ctrl(); in_data = d1;
    tick();
    in_ctrl = rnd_ctrl(); in_data = d2;
    tick();
    chk("t3_state_two", dbg_state, TWO);
    flush = 1'b1; in_ctrl = 5'b11111; in_data = rnd_data();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_out_valid", out_valid, 0);
    chk("t3_out_ctrl", out_ctrl, 0);
    chk("t3_in_ready", in_ready, 1);
    chk("t3_data_kept", out_data, d1);
    chk("t3_stall_kept", stall_cnt, 4);
    chk("t3_state_empty", dbg_state, EMPTY);
    out_ready = 1'b1;
    tick(); tick();
    chk("t3_d_dropped", out_valid, 0);

    // 6: reset in ONE overrides flush and input
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = rnd_ctrl(); in_data = rnd_data();
    tick();
    chk("t6_state_one", dbg_state, ONE);
    rst = 1'b1; flush = 1'b1; in_ctrl = rnd_ctrl(); in_data = rnd_data();
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_ctrl", out_ctrl, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_stall_cnt", stall_cnt, 0);
    chk("t6_in_ready", in_ready, 1);

    // 4: stall counter saturation
    in_valid = 1'b1; in_ctrl = rnd_ctrl(); in_data = rnd_data();
    tick();
    in_valid = 1'b0;
    repeat (70000) tick();
    chk("t4_saturated", stall_cnt, 16'hFFFF);
    tick();
    chk("t4_stays", stall_cnt, 16'hFFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush_keeps", stall_cnt, 16'hFFFF);
    chk("t4_flush_bubble", out_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_clears", stall_cnt, 0);

    // 5: SKID=0 streaming, then one-cycle backpressure
    in_valid0 = 1'b1; out_ready0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = rnd_data(); c = rnd_ctrl();
      in_data0 = d; in_ctrl0 = c;
      #1;
      chk("t5_stream_ready", in_ready0, 1);
      tick();
      chk("t5_stream_valid", out_valid0, 1);
      chk("t5_stream_data", out_data0, d);
      chk("t5_stream_ctrl", out_ctrl0, c);
    end
    dx = rnd_data(); dy = rnd_data();
    in_data0 = dx; in_ctrl0 = rnd_ctrl();
    tick();
    out_ready0 = 1'b0; in_data0 = dy; in_ctrl0 = rnd_ctrl();
    #1;
    chk("t5_bp_not_ready", in_ready0, 0);
    tick();
    chk("t5_bp_head_held", out_data0, dx);
    out_ready0 = 1'b1;
    #1;
    chk("t5_bp_ready_again", in_ready0, 1);
    tick();
    in_valid0 = 1'b0;
    chk("t5_head_y", out_data0, dy);
    tick();
    chk("t5_drained", out_valid0, 0);
    chk("t5_stall_cnt", stall_cnt0, 1);

    tick();
    chk("sb_skid_drain", exp_q.size(), 0);
    chk("sb_noskid_drain", exp0_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
